// File: rtl/ttc_bcid_evid_tracker_if.sv
// TTC tracker bus: decoded TTC strobes and configuration in, BCID/event tagging out.
// The master is the TTC decoder side and the slave is the tracker.
interface ttc_bcid_evid_tracker_if #(
  parameter int unsigned BCID_W = 12,
  parameter int unsigned EVID_W = 32,
  parameter int unsigned DEAD_W = 8
);
  logic              bcr;
  logic              ecr;
  logic              l1a;
  logic [BCID_W-1:0] cfg_latency;
  logic [DEAD_W-1:0] cfg_dead;
  logic [BCID_W-1:0] bcid;
  logic              locked;
  logic              bcr_err;
  logic [15:0]       err_cnt;
  logic              l1a_acc;
  logic              l1a_veto;
  logic [BCID_W-1:0] l1a_bcid;
  logic [EVID_W-1:0] l1a_evid;

  modport master (
    output bcr, ecr, l1a, cfg_latency, cfg_dead,
    input  bcid, locked, bcr_err, err_cnt, l1a_acc, l1a_veto, l1a_bcid, l1a_evid
  );

  modport slave (
    input  bcr, ecr, l1a, cfg_latency, cfg_dead,
    output bcid, locked, bcr_err, err_cnt, l1a_acc, l1a_veto, l1a_bcid, l1a_evid
  );
endinterface

// File: rtl/ttc_bcid_evid_tracker.sv
// TTC timing tracker: BCR-locked BCID counter, L1A dead time, event ID counting,
// latency-compensated crossing tags and BCR sync error detection.
module ttc_bcid_evid_tracker #(
  parameter int unsigned BCID_MAX = 3564,
  parameter int unsigned BCID_W   = 12,
  parameter int unsigned EVID_W   = 32,
  parameter int unsigned DEAD_W   = 8
) (
  input  logic                  clk40,
  input  logic                  rst_n,
  ttc_bcid_evid_tracker_if.slave bus
);
  localparam logic [BCID_W-1:0] BCID_LAST  = BCID_W'(BCID_MAX - 1);
  localparam logic [BCID_W:0]   BCID_MAX_X = (BCID_W + 1)'(BCID_MAX);

  typedef enum logic {
    ST_UNLOCKED,
    ST_LOCKED
  } lock_state_e;

  lock_state_e       state_q, state_d;
  logic              err_d;
  logic              locked;

  logic [BCID_W-1:0] bcid_q, bcid_d;
  logic              bcr_err_q;
  logic [15:0]       err_cnt_q;
  logic [DEAD_W-1:0] dead_q, dead_d;
  logic [EVID_W-1:0] evid_q, evid_d, evid_base;
  logic              accept;
  logic [BCID_W:0]   lat_x, b_x;
  logic [BCID_W-1:0] tag_d;
  logic              l1a_acc_q, l1a_veto_q;
  logic [BCID_W-1:0] l1a_bcid_q;
  logic [EVID_W-1:0] l1a_evid_q;

  assign locked = (state_q == ST_LOCKED);

  // Lock FSM; a misplaced BCR keeps lock, a missing one drops it.
  always_ff @(posedge clk40) begin
    if (!rst_n) state_q <= ST_UNLOCKED;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    case (state_q)
      ST_UNLOCKED: begin
        if (bus.bcr) state_d = ST_LOCKED;
      end
      ST_LOCKED: begin
        if (bus.bcr && (bcid_q != BCID_LAST)) begin
          err_d = 1'b1;
        end else if (!bus.bcr && (bcid_q == BCID_LAST)) begin
          err_d   = 1'b1;
          state_d = ST_UNLOCKED;
        end
      end
      default: state_d = ST_UNLOCKED;
    endcase
  end

  always_comb begin
    bcid_d = bcid_q + BCID_W'(1);
    if (bus.bcr || (bcid_q == BCID_LAST)) bcid_d = '0;

    accept = bus.l1a && (dead_q == '0) && locked;

    dead_d = dead_q;
    if (accept)              dead_d = bus.cfg_dead;
    else if (dead_q != '0)   dead_d = dead_q - DEAD_W'(1);

    // ECR takes effect before the coincident L1A reads the event ID.
    evid_base = bus.ecr ? '0 : evid_q;
    evid_d    = accept ? evid_base + EVID_W'(1) : evid_base;

    lat_x = {1'b0, bus.cfg_latency};
    if (lat_x >= BCID_MAX_X) lat_x = '0;
    b_x = {1'b0, bcid_q};
    if (b_x >= lat_x) tag_d = BCID_W'(b_x - lat_x);
    else              tag_d = BCID_W'(b_x + BCID_MAX_X - lat_x);
  end

  always_ff @(posedge clk40) begin
    if (!rst_n) begin
      bcid_q     <= '0;
      bcr_err_q  <= 1'b0;
      err_cnt_q  <= '0;
      dead_q     <= '0;
      evid_q     <= '0;
      l1a_acc_q  <= 1'b0;
      l1a_veto_q <= 1'b0;
      l1a_bcid_q <= '0;
      l1a_evid_q <= '0;
    end else begin
      bcid_q     <= bcid_d;
      bcr_err_q  <= err_d;
      if (err_d && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 16'd1;
      dead_q     <= dead_d;
      evid_q     <= evid_d;
      l1a_acc_q  <= accept;
      l1a_veto_q <= bus.l1a && !accept;
      if (accept) begin
        l1a_bcid_q <= tag_d;
        l1a_evid_q <= evid_base;
      end
    end
  end

  assign bus.bcid     = bcid_q;
  assign bus.locked   = locked;
  assign bus.bcr_err  = bcr_err_q;
  assign bus.err_cnt  = err_cnt_q;
  assign bus.l1a_acc  = l1a_acc_q;
  assign bus.l1a_veto = l1a_veto_q;
  assign bus.l1a_bcid = l1a_bcid_q;
  assign bus.l1a_evid = l1a_evid_q;
endmodule

// File: tb/tb_ttc_bcid_evid_tracker.sv
// Bench for ttc_bcid_evid_tracker with a 200-crossing orbit: random and directed
// TTC traffic compared each cycle against a cycle-indexed reference model.
module tb_ttc_bcid_evid_tracker;
  localparam int unsigned BCID_MAX = 200;
  localparam int unsigned BCID_W   = 12;
  localparam int unsigned EVID_W   = 32;
  localparam int unsigned DEAD_W   = 8;

  logic clk = 1'b0;
  logic rst_n;

  ttc_bcid_evid_tracker_if #(.BCID_W(BCID_W), .EVID_W(EVID_W), .DEAD_W(DEAD_W)) bus ();

  ttc_bcid_evid_tracker #(
    .BCID_MAX(BCID_MAX),
    .BCID_W  (BCID_W),
    .EVID_W  (EVID_W),
    .DEAD_W  (DEAD_W)
  ) dut (
    .clk40(clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;

  // Reference state: dead time as an absolute "next allowed cycle" index.
  int          m_bcid, m_locked, m_err, m_errcnt, m_acc, m_veto, m_lbcid;
  longint      m_cyc, m_next_ok;
  logic [31:0] m_e, m_evid;

  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model();
    int lat;
    bit acc;
    if (!rst_n) begin
      m_bcid = 0; m_locked = 0; m_err = 0; m_errcnt = 0; m_acc = 0; m_veto = 0;
      m_lbcid = 0; m_next_ok = 0; m_e = 0; m_evid = 0;
      m_cyc++;
      return;
    end
    lat = (int'(bus.cfg_latency) >= BCID_MAX) ? 0 : int'(bus.cfg_latency);
    acc = bus.l1a && (m_locked != 0) && (m_cyc >= m_next_ok);
    m_acc  = acc ? 1 : 0;
    m_veto = (bus.l1a && !acc) ? 1 : 0;
    if (acc) begin
      m_lbcid   = (m_bcid - lat + BCID_MAX) % BCID_MAX;
      m_evid    = bus.ecr ? 32'd0 : m_e;
      m_e       = m_evid + 32'd1;
      m_next_ok = m_cyc + longint'(bus.cfg_dead) + 1;
    end else if (bus.ecr) begin
      m_e = 0;
    end
    m_err = 0;
    if (m_locked != 0) begin
      if (bus.bcr && m_bcid != BCID_MAX - 1) m_err = 1;
      else if (!bus.bcr && m_bcid == BCID_MAX - 1) begin
        m_err = 1;
        m_locked = 0;
      end
    end else if (bus.bcr) begin
      m_locked = 1;
    end
    if (m_err != 0 && m_errcnt < 65535) m_errcnt++;
    m_bcid = bus.bcr ? 0 : (m_bcid + 1) % BCID_MAX;
    m_cyc++;
  endtask

  task automatic compare_all();
    check("bcid",     bus.bcid,     m_bcid);
    check("locked",   bus.locked,   m_locked);
    check("bcr_err",  bus.bcr_err,  m_err);
    check("err_cnt",  bus.err_cnt,  m_errcnt);
    check("l1a_acc",  bus.l1a_acc,  m_acc);
    check("l1a_veto", bus.l1a_veto, m_veto);
    check("l1a_bcid", bus.l1a_bcid, m_lbcid);
    check("l1a_evid", bus.l1a_evid, m_evid);
  endtask

  task automatic step(input bit bcr_i, input bit ecr_i, input bit l1a_i);
    bus.bcr = bcr_i;
    bus.ecr = ecr_i;
    bus.l1a = l1a_i;
    @(posedge clk);
    #1;
    model();
    compare_all();
  endtask

  function automatic bit wrap();
    return m_bcid == BCID_MAX - 1;
  endfunction

  task automatic run_to(input int target);
    for (int i = 0; i < 2 * BCID_MAX && m_bcid != target; i++) step(wrap(), 1'b0, 1'b0);
    check("run_to", m_bcid, target);
  endtask

  task automatic rand_run(input int n);
    for (int i = 0; i < n; i++)
      step(wrap(), $urandom_range(0, 49) == 0, $urandom_range(0, 99) < 15);
  endtask

  initial begin
    int n;
    m_cyc = 0;
    rst_n = 1'b0;
    bus.bcr = 1'b0; bus.ecr = 1'b0; bus.l1a = 1'b0;
    bus.cfg_latency = '0;
    bus.cfg_dead    = '0;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0);
    check("rst_bcid",   bus.bcid,    0);
    check("rst_locked", bus.locked,  0);
    check("rst_errcnt", bus.err_cnt, 0);

    // Clean orbits: lock on first BCR, then no errors.
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    check("lock_first", bus.locked, 1);
    for (int i = 0; i < 450; i++) step(wrap(), 1'b0, 1'b0);
    check("clean_errcnt", bus.err_cnt, 0);
    check("clean_locked", bus.locked, 1);

    bus.cfg_latency = BCID_W'($urandom_range(0, BCID_MAX - 1));
    bus.cfg_dead    = DEAD_W'($urandom_range(0, 7));
    rand_run(600);
    bus.cfg_latency = BCID_W'($urandom_range(BCID_MAX, 4095));
    rand_run(200);

    // Misplaced BCR.
    run_to(57);
    step(1'b1, 1'b0, 1'b0);
    check("mis_err",    bus.bcr_err, 1);
    check("mis_bcid",   bus.bcid,    0);
    check("mis_locked", bus.locked,  1);
    check("mis_cnt",    bus.err_cnt, 1);
    step(wrap(), 1'b0, 1'b0);
    check("mis_pulse", bus.bcr_err, 0);

    // Missing BCR, then an L1A while unlocked.
    bus.cfg_dead = '0;
    run_to(BCID_MAX - 1);
    step(1'b0, 1'b0, 1'b0);
    check("miss_err",    bus.bcr_err, 1);
    check("miss_locked", bus.locked,  0);
    check("miss_cnt",    bus.err_cnt, 2);
    step(1'b0, 1'b0, 1'b1);
    check("unl_veto", bus.l1a_veto, 1);
    check("unl_acc",  bus.l1a_acc,  0);
    step(1'b1, 1'b0, 1'b0);
    check("relock", bus.locked, 1);

    // Latency compensation.
    bus.cfg_latency = 12'd30;
    run_to(10);
    step(wrap(), 1'b0, 1'b1);
    check("lat10_acc",  bus.l1a_acc,  1);
    check("lat10_bcid", bus.l1a_bcid, 180);
    run_to(40);
    step(wrap(), 1'b0, 1'b1);
    check("lat40_bcid", bus.l1a_bcid, 10);
    run_to(30);
    step(wrap(), 1'b0, 1'b1);
    check("lat30_bcid", bus.l1a_bcid, 0);

    // Dead time with L1A held high.
    bus.cfg_dead = 8'd60;
    n = 0;
    for (int i = 0; i < 250; i++) begin
      step(wrap(), 1'b0, 1'b1);
      if (bus.l1a_acc) n++;
    end
    check("dead60_count", n, 5);
    bus.cfg_dead = '0;
    for (int i = 0; i < 70; i++) step(wrap(), 1'b0, 1'b0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step(wrap(), 1'b0, 1'b1);
      if (bus.l1a_acc) n++;
    end
    check("dead0_count", n, 20);

    // ECR coincident with accepted, then with vetoed L1A.
    step(wrap(), 1'b1, 1'b1);
    check("ecr_acc",  bus.l1a_acc,  1);
    check("ecr_evid", bus.l1a_evid, 0);
    step(wrap(), 1'b0, 1'b1);
    check("ecr_next", bus.l1a_evid, 1);
    bus.cfg_dead = 8'd5;
    step(wrap(), 1'b0, 1'b1);
    step(wrap(), 1'b1, 1'b1);
    check("ecr_veto", bus.l1a_veto, 1);
    for (int i = 0; i < 6; i++) step(wrap(), 1'b0, 1'b0);
    step(wrap(), 1'b0, 1'b1);
    check("ecr_veto_evid", bus.l1a_evid, 0);

    // Mid-run reset.
    bus.cfg_dead    = 8'd3;
    bus.cfg_latency = BCID_W'($urandom_range(0, BCID_MAX - 1));
    rand_run(100);
    rst_n = 1'b0;
    step(1'b0, 1'b0, 1'b1);
    check("mrst_bcid",   bus.bcid,     0);
    check("mrst_locked", bus.locked,   0);
    check("mrst_errcnt", bus.err_cnt,  0);
    check("mrst_acc",    bus.l1a_acc,  0);
    check("mrst_veto",   bus.l1a_veto, 0);
    check("mrst_lbcid",  bus.l1a_bcid, 0);
    check("mrst_evid",   bus.l1a_evid, 0);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    rand_run(300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
